// File: rtl/lenet_pkg.sv
// Shared constants and FSM state type for the LeNet layer blocks.
package lenet_pkg;

  localparam int FC1_N_IN  = 400;
  localparam int FC1_N_OUT = 120;
  localparam int FC1_SHIFT = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_BIAS,
    MAC,
    FLUSH,
    WRITE,
    DONE
  } fc1_state_t;

endpackage

// File: rtl/lenet_mac_int8.sv
// Registered int8 x int8 multiply-accumulate into a wrapping 32-bit accumulator.
module lenet_mac_int8
  import lenet_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               acc_en,
  input  logic signed [31:0] load_val,
  input  logic signed [7:0]  a,
  input  logic signed [7:0]  b,
  output logic signed [31:0] acc
);

  logic signed [15:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else if (acc_en) begin
      acc <= acc + 32'(prod);
    end
  end

endmodule

// File: rtl/lenet_fc1.sv
// LeNet FC1 layer: N_IN-input, N_OUT-neuron int8 fully connected layer with requantization.
// Optional ReLU before saturation is enabled by defining LENET_FC1_RELU_EN.
module lenet_fc1
  import lenet_pkg::*;
#(
  parameter int N_IN  = FC1_N_IN,
  parameter int N_OUT = FC1_N_OUT,
  parameter int SHIFT = FC1_SHIFT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [8:0]         in_addr,
  input  logic signed [7:0]  in_rd_data,
  output logic [15:0]        w_addr,
  input  logic signed [7:0]  w_rd_data,
  output logic [6:0]         b_addr,
  input  logic signed [31:0] b_rd_data,
  output logic [6:0]         out_addr,
  output logic signed [7:0]  out_wr_data,
  output logic               out_wr_en
);

`ifdef LENET_FC1_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  fc1_state_t         state, state_next;
  logic [6:0]         n;
  logic [8:0]         k;
  logic               last_k, last_n;
  logic               mac_load, mac_acc;
  logic signed [31:0] acc;
  logic signed [31:0] shifted;
  logic signed [7:0]  y;

  assign last_k = (k == 9'(N_IN - 1));
  assign last_n = (n == 7'(N_OUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n     <= '0;
      k     <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE:      if (start) n <= '0;
        LOAD_BIAS: k <= '0;
        MAC:       if (!last_k) k <= k + 9'd1;
        WRITE:     if (!last_n) n <= n + 7'd1;
        default:   ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start) state_next = LOAD_BIAS;
      LOAD_BIAS: state_next = MAC;
      MAC:       if (last_k) state_next = FLUSH;
      FLUSH:     state_next = WRITE;
      WRITE:     state_next = last_n ? DONE : LOAD_BIAS;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Read data lags the address by one cycle, so MAC cycle k accumulates
  // element k-1 and the first MAC cycle instead takes the bias fetched in LOAD_BIAS.
  assign mac_load = (state == MAC) && (k == 9'd0);
  assign mac_acc  = ((state == MAC) && (k != 9'd0)) || (state == FLUSH);

  lenet_mac_int8 u_mac (
    .clk      (clk),
    .rst      (rst),
    .load     (mac_load),
    .acc_en   (mac_acc),
    .load_val (b_rd_data),
    .a        (in_rd_data),
    .b        (w_rd_data),
    .acc      (acc)
  );

  always_comb begin
    shifted = acc >>> SHIFT;
    if (RELU_EN && (shifted < 0)) begin
      shifted = '0;
    end
    if (shifted > 127) begin
      y = 8'sd127;
    end else if (shifted < -128) begin
      y = -8'sd128;
    end else begin
      y = shifted[7:0];
    end
  end

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign out_wr_en   = (state == WRITE);
  assign out_wr_data = (state == WRITE) ? y : '0;
  assign in_addr     = k;
  assign w_addr      = 16'(n) * 16'(N_IN) + 16'(k);
  assign b_addr      = n;
  assign out_addr    = n;

endmodule

// File: tb/tb_lenet_fc1.sv
// Directed bench for lenet_fc1: a default-size instance and a 3-neuron, SHIFT=0 instance.
module tb_lenet_fc1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int run_id = 0;

  // Instance A: default parameters
  logic               rst_a, start_a, busy_a, done_a, wr_en_a;
  logic [8:0]         in_addr_a;
  logic [15:0]        w_addr_a;
  logic [6:0]         b_addr_a, out_addr_a;
  logic signed [7:0]  x_q_a, w_q_a, out_data_a;
  logic signed [31:0] b_q_a;

  // Instance B: 3 neurons, no requantization shift
  logic               rst_b, start_b, busy_b, done_b, wr_en_b;
  logic [8:0]         in_addr_b;
  logic [15:0]        w_addr_b;
  logic [6:0]         b_addr_b, out_addr_b;
  logic signed [7:0]  x_q_b, w_q_b, out_data_b;
  logic signed [31:0] b_q_b;

  lenet_fc1 dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
    .in_addr(in_addr_a), .in_rd_data(x_q_a), .w_addr(w_addr_a), .w_rd_data(w_q_a),
    .b_addr(b_addr_a), .b_rd_data(b_q_a), .out_addr(out_addr_a),
    .out_wr_data(out_data_a), .out_wr_en(wr_en_a)
  );

  lenet_fc1 #(.N_IN(400), .N_OUT(3), .SHIFT(0)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
    .in_addr(in_addr_b), .in_rd_data(x_q_b), .w_addr(w_addr_b), .w_rd_data(w_q_b),
    .b_addr(b_addr_b), .b_rd_data(b_q_b), .out_addr(out_addr_b),
    .out_wr_data(out_data_b), .out_wr_en(wr_en_b)
  );

  logic signed [7:0]  x_a [512];
  logic signed [7:0]  w_a [65536];
  logic signed [31:0] b_a [128];
  logic signed [7:0]  x_b [512];
  logic signed [7:0]  w_b [65536];
  logic signed [31:0] b_b [128];

  always @(posedge clk) begin
    x_q_a <= x_a[in_addr_a];
    w_q_a <= w_a[w_addr_a];
    b_q_a <= b_a[b_addr_a];
    x_q_b <= x_b[in_addr_b];
    w_q_b <= w_b[w_addr_b];
    b_q_b <= b_b[b_addr_b];
  end

  // Output buffers tagged with the run that wrote them, so stale entries are caught
  logic signed [7:0] out_a [128];
  logic signed [7:0] out_b [128];
  int tag_a [128];
  int tag_b [128];
  int wr_cnt_a = 0, done_cnt_a = 0, wr_cnt_b = 0;

  always @(posedge clk) begin
    if (wr_en_a) begin
      out_a[out_addr_a] <= out_data_a;
      tag_a[out_addr_a] <= run_id;
      wr_cnt_a <= wr_cnt_a + 1;
    end
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (wr_en_b) begin
      out_b[out_addr_b] <= out_data_b;
      tag_b[out_addr_b] <= run_id;
      wr_cnt_b <= wr_cnt_b + 1;
    end
  end

  task automatic fill_b(input int xv, input int w0, input int w1, input int w2,
                        input int b0, input int b1, input int b2);
    for (int i = 0; i < 512; i++) x_b[i] = (i < 400) ? 8'(xv) : 8'sd0;
    for (int i = 0; i < 400; i++) begin
      w_b[i]       = 8'(w0);
      w_b[400 + i] = 8'(w1);
      w_b[800 + i] = 8'(w2);
    end
    b_b[0] = b0;
    b_b[1] = b1;
    b_b[2] = b2;
  endtask

  task automatic run_b(output int done_cyc);
    done_cyc = -1;
    @(negedge clk) start_b = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (done_b) begin
        done_cyc = c;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy_a, done_a, wr_en_a} !== 3'b000) begin
      n_err++; $display("[TB] FAIL reset_ctrl_a got %b want 000", {busy_a, done_a, wr_en_a});
    end
    n_cmp++;
    if ({in_addr_a, w_addr_a, b_addr_a, out_addr_a, out_data_a} !== 47'd0) begin
      n_err++; $display("[TB] FAIL reset_addr_a got %h want 0", {in_addr_a, w_addr_a, b_addr_a, out_addr_a, out_data_a});
    end
    n_cmp++;
    if ({busy_b, done_b, wr_en_b} !== 3'b000) begin
      n_err++; $display("[TB] FAIL reset_ctrl_b got %b want 000", {busy_b, done_b, wr_en_b});
    end
    n_cmp++;
    if ({in_addr_b, w_addr_b, b_addr_b, out_addr_b, out_data_b} !== 47'd0) begin
      n_err++; $display("[TB] FAIL reset_addr_b got %h want 0", {in_addr_b, w_addr_b, b_addr_b, out_addr_b, out_data_b});
    end
  endtask

  // Full default-size run: last-element flush, floor/saturation/wrap cases, start re-pulses, done timing
  task automatic test_full_run();
    int cyc, done_cyc, wr0, dn0;
    logic signed [7:0] exp_v [120];
    for (int i = 0; i < 512; i++) x_a[i] = '0;
    for (int i = 0; i < 65536; i++) w_a[i] = '0;
    for (int i = 0; i < 128; i++) b_a[i] = '0;
    x_a[399] = -8'sd128; w_a[399] = -8'sd128;
    b_a[1] = -1; b_a[2] = 255; b_a[3] = -257; b_a[4] = 40000;
    x_a[0] = 8'sd5; w_a[2000] = 8'sd100; b_a[5] = 12;
    w_a[2400] = 8'sd1; b_a[6] = 32'sh7FFF_FFFF;
    b_a[119] = -40000;
    for (int i = 0; i < 120; i++) exp_v[i] = '0;
    exp_v[0] = 8'sd64;
    exp_v[4] = 8'sd127;
    exp_v[5] = 8'sd2;
`ifndef LENET_FC1_RELU_EN
    exp_v[1]   = -8'sd1;
    exp_v[3]   = -8'sd2;
    exp_v[6]   = -8'sd128;
    exp_v[119] = -8'sd128;
`endif
    run_id = 1;
    wr0 = wr_cnt_a; dn0 = done_cnt_a; done_cyc = -1; cyc = 0;
    @(negedge clk) start_a = 1'b1;
    while (cyc < 48400) begin
      @(negedge clk);
      cyc++;
      start_a = (cyc == 5 || cyc == 20000 || cyc == 48361);
      if (cyc == 1) begin
        n_cmp++;
        if (busy_a !== 1'b1) begin
          n_err++; $display("[TB] FAIL busy_after_start got %b want 1", busy_a);
        end
      end
      if (cyc == 402) begin
        n_cmp++;
        if (wr_en_a !== 1'b0) begin
          n_err++; $display("[TB] FAIL no_write_in_flush got %b want 0", wr_en_a);
        end
      end
      if (cyc == 403) begin
        n_cmp++;
        if ({wr_en_a, out_addr_a, out_data_a} !== {1'b1, 7'd0, 8'sd64}) begin
          n_err++; $display("[TB] FAIL write_n0 got en=%b addr=%0d data=%0d want en=1 addr=0 data=64",
                            wr_en_a, out_addr_a, out_data_a);
        end
      end
      if (cyc == 818) begin
        n_cmp++;
        if ({in_addr_a, w_addr_a, b_addr_a} !== {9'd10, 16'd810, 7'd2}) begin
          n_err++; $display("[TB] FAIL addr_n2_k10 got in=%0d w=%0d b=%0d want in=10 w=810 b=2",
                            in_addr_a, w_addr_a, b_addr_a);
        end
      end
      if (done_a && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc >= done_cyc + 5) break;
    end
    start_a = 1'b0;
    n_cmp++;
    if (done_cyc !== 48361) begin
      n_err++; $display("[TB] FAIL done_cycle got %0d want 48361", done_cyc);
    end
    n_cmp++;
    if (done_cnt_a - dn0 !== 1) begin
      n_err++; $display("[TB] FAIL done_pulses got %0d want 1", done_cnt_a - dn0);
    end
    n_cmp++;
    if (wr_cnt_a - wr0 !== 120) begin
      n_err++; $display("[TB] FAIL write_count_a got %0d want 120", wr_cnt_a - wr0);
    end
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_err++; $display("[TB] FAIL idle_after_done got %b want 0", busy_a);
    end
    for (int i = 0; i < 120; i++) begin
      n_cmp++;
      if (tag_a[i] !== run_id || out_a[i] !== exp_v[i]) begin
        n_err++; $display("[TB] FAIL out_a[%0d] got %0d (run %0d) want %0d (run %0d)",
                          i, out_a[i], tag_a[i], exp_v[i], run_id);
      end
    end
  endtask

  task automatic test_saturation();
    int dc, wr0;
    fill_b(1, 1, 1, 1, 0, 0, 0);
    run_id++; wr0 = wr_cnt_b;
    run_b(dc);
    n_cmp++;
    if (dc !== 1210) begin
      n_err++; $display("[TB] FAIL sat_done_cycle got %0d want 1210", dc);
    end
    n_cmp++;
    if (wr_cnt_b - wr0 !== 3) begin
      n_err++; $display("[TB] FAIL sat_write_count got %0d want 3", wr_cnt_b - wr0);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (tag_b[i] !== run_id || out_b[i] !== 8'sd127) begin
        n_err++; $display("[TB] FAIL sat_out[%0d] got %0d (run %0d) want 127 (run %0d)", i, out_b[i], tag_b[i], run_id);
      end
    end
  endtask

  task automatic test_bias_only();
    int dc;
    logic signed [7:0] e;
`ifdef LENET_FC1_RELU_EN
    e = 8'sd0;
`else
    e = -8'sd5;
`endif
    fill_b(0, 1, 1, 1, -5, -5, -5);
    run_id++;
    run_b(dc);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (tag_b[i] !== run_id || out_b[i] !== e) begin
        n_err++; $display("[TB] FAIL bias_out[%0d] got %0d (run %0d) want %0d (run %0d)", i, out_b[i], tag_b[i], e, run_id);
      end
    end
  endtask

  task automatic test_mixed();
    int dc;
    logic signed [7:0] exp_v [3];
    exp_v[0] = 8'sd127;
`ifdef LENET_FC1_RELU_EN
    exp_v[1] = 8'sd0;
`else
    exp_v[1] = -8'sd128;
`endif
    exp_v[2] = 8'sd37;
    fill_b(2, 1, -1, 0, 0, 0, 37);
    run_id++;
    run_b(dc);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (tag_b[i] !== run_id || out_b[i] !== exp_v[i]) begin
        n_err++; $display("[TB] FAIL mixed_out[%0d] got %0d (run %0d) want %0d (run %0d)", i, out_b[i], tag_b[i], exp_v[i], run_id);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int dc, wr0;
    logic signed [7:0] exp_v [3];
    fill_b(1, 1, 1, 1, 0, 0, 0);
    run_id++; wr0 = wr_cnt_b;
    @(negedge clk) start_b = 1'b1;
    for (int c = 1; c <= 503; c++) begin
      @(negedge clk);
      start_b = 1'b0;
    end
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    n_cmp++;
    if ({busy_b, done_b, wr_en_b, in_addr_b, w_addr_b, out_data_b} !== 36'd0) begin
      n_err++; $display("[TB] FAIL midrst_outputs got busy=%b done=%b en=%b in=%0d w=%0d data=%0d want all 0",
                        busy_b, done_b, wr_en_b, in_addr_b, w_addr_b, out_data_b);
    end
    repeat (1300) @(negedge clk);
    n_cmp++;
    if (wr_cnt_b - wr0 !== 1) begin
      n_err++; $display("[TB] FAIL midrst_writes got %0d want 1", wr_cnt_b - wr0);
    end
    exp_v[0] = 8'sd127;
`ifdef LENET_FC1_RELU_EN
    exp_v[1] = 8'sd0;
`else
    exp_v[1] = -8'sd128;
`endif
    exp_v[2] = 8'sd37;
    fill_b(2, 1, -1, 0, 0, 0, 37);
    run_id++; wr0 = wr_cnt_b;
    run_b(dc);
    n_cmp++;
    if (dc !== 1210 || wr_cnt_b - wr0 !== 3) begin
      n_err++; $display("[TB] FAIL restart_run got done_cycle=%0d writes=%0d want 1210 and 3", dc, wr_cnt_b - wr0);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (tag_b[i] !== run_id || out_b[i] !== exp_v[i]) begin
        n_err++; $display("[TB] FAIL restart_out[%0d] got %0d (run %0d) want %0d (run %0d)", i, out_b[i], tag_b[i], exp_v[i], run_id);
      end
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    test_reset();
    test_saturation();
    test_bias_only();
    test_mixed();
    test_reset_mid_run();
    test_full_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
